// File: rtl/host_bus_seq.sv
// host_bus_seq: host-bus master for the MAC register interface.
// After reset it waits START_DLY cycles and then replays a register-init
// script from an external registered ROM. Each entry becomes one write strobe.
// Once the script completes it raises CPU_init_end and serves single runtime
// read/write requests through a req/ack handshake.
// Every bus-facing output is driven straight from a flop.
module host_bus_seq #(
  parameter int STROBE_CYC = 3,
  parameter int GAP_CYC    = 3,
  parameter int START_DLY  = 11,
  parameter int ROM_AW     = 8
) (
  input  logic              Reset,
  input  logic              Clk_reg,
  output logic [ROM_AW-1:0] Rom_addr,
  input  logic [31:0]       Rom_data,
  input  logic              Req,
  input  logic              Req_wr,
  input  logic [6:0]        Req_addr,
  input  logic [15:0]       Req_wdata,
  output logic              Ack,
  output logic [15:0]       Rdata,
  output logic              CSB,
  output logic              WRB,
  output logic [7:0]        CA,
  output logic [15:0]       CD_in,
  input  logic [15:0]       CD_out,
  output logic              CPU_init_end,
  output logic              Busy
);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STROBE = 3'd3,
    ST_GAP    = 3'd4,
    ST_IDLE   = 3'd5
  } state_t;

  // Last value of the phase counter in each timed state.
  localparam logic [15:0] WAIT_LAST   = 16'(START_DLY - 1);
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYC - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYC - 1);

  state_t state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [7:0] idx_r, idx_s, idx_inc_s;
  logic [7:0] n_r, n_s;
  logic [ROM_AW-1:0] rom_addr_r, rom_addr_s;
  logic csb_r, csb_s;
  logic wrb_r, wrb_s;
  logic [7:0] ca_r, ca_s;
  logic [15:0] cd_r, cd_s;
  logic ack_r, ack_s;
  logic [15:0] rdata_r, rdata_s;
  logic init_end_r, init_end_s;
  logic busy_r, busy_s;
  logic unused_rom_addr7_s;

  // The ROM address field is 8 bits, but only bits [6:0] form the word address.
  assign unused_rom_addr7_s = Rom_data[23];
  assign idx_inc_s = idx_r + 8'd1;

  // State register and phase counter
  always_ff @(posedge Clk_reg or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_WAIT;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic. After init, every GAP exit returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_WAIT: begin
        if (cnt_r == WAIT_LAST) state_s = ST_FETCH;
        else                    state_s = ST_WAIT;
      end
      ST_FETCH: begin
        state_s = ST_LOAD;
      end
      ST_LOAD: begin
        if (idx_r == 8'd0 && Rom_data[31:24] == 8'd0) state_s = ST_IDLE;
        else                                            state_s = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_r == STROBE_LAST) state_s = ST_GAP;
        else                      state_s = ST_STROBE;
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          if (init_end_r || idx_inc_s == n_r) state_s = ST_IDLE;
          else                                state_s = ST_FETCH;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_IDLE: begin
        if (Req) state_s = ST_STROBE;
        else     state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_WAIT;
      end
    endcase
  end

  // Next values of the counter, script bookkeeping and all registered outputs
  always_comb begin
    rom_addr_s = rom_addr_r;
    idx_s      = idx_r;
    n_s        = n_r;
    csb_s      = 1'b1;
    wrb_s      = 1'b1;
    ca_s       = 8'd0;
    cd_s       = 16'd0;
    rdata_s    = rdata_r;
    init_end_s = init_end_r;
    busy_s     = (state_s != ST_IDLE);

    if (state_s != state_r)     cnt_s = 16'd0;
    else if (state_r == ST_IDLE) cnt_s = cnt_r;
    else                         cnt_s = cnt_r + 16'd1;

    case (state_r)
      ST_LOAD: begin
        // Only entry 0 carries the entry count.
        if (idx_r == 8'd0) n_s = Rom_data[31:24];
        else               n_s = n_r;
        if (state_s == ST_STROBE) begin
          csb_s = 1'b0;
          wrb_s = 1'b0;
          ca_s  = {Rom_data[22:16], 1'b0};
          cd_s  = Rom_data[15:0];
        end else begin
          init_end_s = 1'b1;
        end
      end
      ST_IDLE: begin
        if (state_s == ST_STROBE) begin
          csb_s = 1'b0;
          wrb_s = ~Req_wr;
          ca_s  = {Req_addr, 1'b0};
          if (Req_wr) cd_s = Req_wdata;
          else        cd_s = 16'd0;
        end else begin
          csb_s = 1'b1;
        end
      end
      ST_STROBE: begin
        if (state_s == ST_STROBE) begin
          // Hold address, data and direction stable for the whole strobe.
          csb_s = csb_r;
          wrb_s = wrb_r;
          ca_s  = ca_r;
          cd_s  = cd_r;
        end else if (init_end_r && wrb_r) begin
          // Runtime read: sample the MAC on the edge that leaves STROBE.
          rdata_s = CD_out;
        end else begin
          rdata_s = rdata_r;
        end
      end
      ST_GAP: begin
        if (state_s == ST_FETCH) begin
          idx_s      = idx_inc_s;
          rom_addr_s = ROM_AW'(idx_inc_s);
        end else if (state_s == ST_IDLE && !init_end_r) begin
          idx_s      = idx_inc_s;
          init_end_s = 1'b1;
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        idx_s = idx_r;
      end
    endcase

    // Ack marks the final gap cycle of a runtime access.
    ack_s = init_end_r && (state_s == ST_GAP) && (cnt_s == GAP_LAST);
  end

  // Output and datapath registers
  always_ff @(posedge Clk_reg or negedge Reset) begin
    if (!Reset) begin
      rom_addr_r <= {ROM_AW{1'b0}};
      idx_r      <= 8'd0;
      n_r        <= 8'd0;
      csb_r      <= 1'b1;
      wrb_r      <= 1'b1;
      ca_r       <= 8'd0;
      cd_r       <= 16'd0;
      ack_r      <= 1'b0;
      rdata_r    <= 16'd0;
      init_end_r <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      rom_addr_r <= rom_addr_s;
      idx_r      <= idx_s;
      n_r        <= n_s;
      csb_r      <= csb_s;
      wrb_r      <= wrb_s;
      ca_r       <= ca_s;
      cd_r       <= cd_s;
      ack_r      <= ack_s;
      rdata_r    <= rdata_s;
      init_end_r <= init_end_s;
      busy_r     <= busy_s;
    end
  end

  assign Rom_addr     = rom_addr_r;
  assign CSB          = csb_r;
  assign WRB          = wrb_r;
  assign CA           = ca_r;
  assign CD_in        = cd_r;
  assign Ack          = ack_r;
  assign Rdata        = rdata_r;
  assign CPU_init_end = init_end_r;
  assign Busy         = busy_r;

endmodule
